// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM states, rcon helpers.
package aes_pkg;

    // AES-128 round count; the key schedule emits AES_NR + 1 round keys.
    localparam int unsigned AES_NR = 10;

    // Width of the round-index field (0..10).
    localparam int unsigned RK_IDX_W = 4;

    // Reduction polynomial term applied by xtime when bit 7 falls off.
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    // First round constant; later ones come from repeated xtime.
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Key-schedule controller states.
    typedef enum logic {
        StIdle,
        StRun
    } ks_state_e;

    // GF(2^8) multiply by x: 01,02,04,...,80,1B,36.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    // Cyclic left byte rotation of a word: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box (8-bit substitution), shared by key schedule and SubBytes.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the top byte, entry 255 in the bottom byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Bit offset of entry i is (255 - i) * 8, i.e. {~i, 3'b000}.
    logic [10:0] base;

    // Table lookup.
    always_comb begin
        base   = {~data_i, 3'b000};
        data_o = SBOX[base +: 8];
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..10 one per valid/ready handshake.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR  // only 10 is supported
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [127:0]        key,
    output logic [127:0]        rk,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [RK_IDX_W-1:0] LastIdx = RK_IDX_W'(NR);

    ks_state_e             state_q;
    logic [127:0]          rk_q;
    logic [RK_IDX_W-1:0]   rk_idx_q;
    logic [7:0]            rcon_q;
    logic                  rk_valid_q;
    logic                  busy_q;
    logic                  done_q;

    // Next round key, computed from the currently presented key.
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot, sub, t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] rk_d;
    logic         hs;

    assign hs = rk_valid_q & rk_ready;

    // One S-box per byte of the rotated last word (SubWord).
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        aes_sbox u_sbox (
            .data_i (rot[8*gi +: 8]),
            .data_o (sub[8*gi +: 8])
        );
    end

    // Single-cycle next-key datapath: RotWord -> SubWord -> rcon -> XOR chain.
    always_comb begin
        {w0, w1, w2, w3} = rk_q;
        rot  = rot_word(w3);
        t    = sub ^ {rcon_q, 24'h000000};
        n0   = w0 ^ t;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        rk_d = {n0, n1, n2, n3};
    end

    // Controller FSM with all outputs registered; start is ignored outside StIdle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rk_q       <= key;
                        rk_idx_q   <= '0;
                        rcon_q     <= RCON_INIT;
                        rk_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (hs) begin
                        if (rk_idx_q == LastIdx) begin
                            // Final key consumed; rk and rk_idx keep their last values.
                            rk_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            rk_q     <= rk_d;
                            rk_idx_q <= rk_idx_q + RK_IDX_W'(1);
                            rcon_q   <= xtime(rcon_q);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rk       = rk_q;
    assign rk_idx   = rk_idx_q;
    assign rk_valid = rk_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
